// File: rtl/ita_package.sv
// Shared types and default geometry for the ITA tile sequencer.
package ita_package;

    localparam int unsigned DefM    = 64;
    localparam int unsigned DefN    = 16;
    localparam int unsigned DefCntW = 16;

    typedef struct packed {
        logic [DefCntW-1:0] inner;
        logic [DefCntW-1:0] tiles_x;
        logic [DefCntW-1:0] tiles_y;
        logic [DefCntW-1:0] valid_rows;
        logic [DefCntW-1:0] valid_cols;
    } step_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ita_credit_counter.sv
// Outstanding-output credit counter: +1 on inc, -1 on dec, unchanged on both.
module ita_credit_counter #(
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned CredW     = $clog2(FifoDepth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CredW-1:0] count_o,
    output logic             full_o
);

    assign full_o = (count_o >= CredW'(FifoDepth));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            count_o <= count_o + CredW'(1);
        end else if (dec_i && !inc_i && (count_o != '0)) begin
            count_o <= count_o - CredW'(1);
        end
    end

    // Popping an output with no credit outstanding means downstream broke protocol.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && (count_o == '0)));

endmodule

// File: rtl/ita_step_sequencer.sv
// Tile sequencer: walks count/inner/tile_x/tile_y/step/head, throttled by output credits.
// Optional ITA_SEQ_STALL_CNT_EN adds a saturating stall_cycles_o counter.
module ita_step_sequencer
    import ita_package::*;
#(
    parameter int unsigned M         = DefM,
    parameter int unsigned N         = DefN,
    parameter int unsigned CntW      = DefCntW,
    parameter int unsigned MaxSteps  = 8,
    parameter int unsigned HeadW     = 4,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned StepW     = $clog2(MaxSteps)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [StepW:0]               num_steps_i,
    input  logic [HeadW-1:0]             num_heads_i,
    input  step_cfg_t [MaxSteps-1:0]     step_cfg_i,
    input  logic                         inp_valid_i,
    output logic                         inp_ready_o,
    input  logic                         weight_valid_i,
    output logic                         weight_ready_o,
    input  logic                         oup_valid_i,
    input  logic                         oup_ready_i,
    output logic                         calc_en_o,
    output logic                         first_inner_o,
    output logic                         last_inner_o,
    output logic [StepW-1:0]             step_idx_o,
    output logic [HeadW-1:0]             head_o,
    output logic [CntW-1:0]              tile_x_o,
    output logic [CntW-1:0]              tile_y_o,
    output logic [CntW-1:0]              inner_tile_o,
    output logic [N-1:0]                 col_mask_o,
    output logic                         busy_o,
    output logic                         done_o
`ifdef ITA_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles_o
`endif
);

    localparam int unsigned Beats  = M * M / N;
    localparam int unsigned CountW = $clog2(Beats);
    localparam int unsigned LogM   = $clog2(M);
    localparam int unsigned LogN   = $clog2(N);
    localparam int unsigned IdxW   = CntW + LogM + 1;
    localparam int unsigned CredW  = $clog2(FifoDepth + 1);

    seq_state_e state_q, state_d;

    logic [CountW-1:0] count_q;
    logic [CntW-1:0]   inner_q, tile_x_q, tile_y_q;
    logic [StepW-1:0]  step_q;
    logic [HeadW-1:0]  head_q;

    logic [CredW-1:0]  credits;
    logic              credit_full;
    logic              run, beat_inc, beat_dec;
    logic              count_wrap, inner_wrap, tx_wrap, ty_wrap, step_wrap, head_wrap;
    logic [IdxW-1:0]   row, col0;

    logic [N-1:0]      col_mask_p1;
    logic              vld_p1;

    step_cfg_t cfg;
    assign cfg = step_cfg_i[step_q];

    // Row boundary drops the whole beat; column boundary trims individual lanes.
    function automatic logic [N-1:0] lane_mask(input logic [IdxW-1:0] r,
                                               input logic [IdxW-1:0] c0,
                                               input step_cfg_t       c);
        logic [N-1:0] m;
        m = '0;
        if (r < IdxW'(c.valid_rows)) begin
            for (int i = 0; i < N; i++) begin
                m[i] = ((c0 + IdxW'(i)) < IdxW'(c.valid_cols));
            end
        end
        return m;
    endfunction

    assign run            = (state_q == RUN);
    assign inp_ready_o    = run && !credit_full && weight_valid_i;
    assign weight_ready_o = run && !credit_full && inp_valid_i;
    assign calc_en_o      = run && !credit_full && inp_valid_i && weight_valid_i;

    assign first_inner_o  = run && (inner_q == '0);
    assign last_inner_o   = run && (inner_q == cfg.inner - CntW'(1));

    assign count_wrap = (count_q == CountW'(Beats - 1));
    assign inner_wrap = count_wrap && (inner_q == cfg.inner - CntW'(1));
    assign tx_wrap    = inner_wrap && (tile_x_q == cfg.tiles_x - CntW'(1));
    assign ty_wrap    = tx_wrap && (tile_y_q == cfg.tiles_y - CntW'(1));
    assign step_wrap  = ty_wrap && ({1'b0, step_q} == num_steps_i - (StepW + 1)'(1));
    assign head_wrap  = step_wrap && (head_q == num_heads_i - HeadW'(1));

    assign row  = (IdxW'(tile_y_q) << LogM) + IdxW'(count_q[LogM-1:0]);
    assign col0 = (IdxW'(tile_x_q) << LogM) + (IdxW'(count_q[CountW-1:LogM]) << LogN);

    assign beat_inc = calc_en_o && last_inner_o;
    assign beat_dec = oup_valid_i && oup_ready_i;

    ita_credit_counter #(
        .FifoDepth (FifoDepth),
        .CredW     (CredW)
    ) i_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (beat_inc),
        .dec_i   (beat_dec),
        .count_o (credits),
        .full_o  (credit_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (calc_en_o && head_wrap) state_d = DRAIN;
            DRAIN: begin
                if ((credits == '0) && !vld_p1) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            inner_q  <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
            step_q   <= '0;
            head_q   <= '0;
        end else if (calc_en_o) begin
            if (head_wrap) begin
                count_q  <= '0;
                inner_q  <= '0;
                tile_x_q <= '0;
                tile_y_q <= '0;
                step_q   <= '0;
                head_q   <= '0;
            end else begin
                count_q <= count_wrap ? '0 : count_q + CountW'(1);
                if (inner_wrap) begin
                    inner_q <= '0;
                    if (tx_wrap) begin
                        tile_x_q <= '0;
                        if (ty_wrap) begin
                            tile_y_q <= '0;
                            if (step_wrap) begin
                                step_q <= '0;
                                head_q <= head_q + HeadW'(1);
                            end else begin
                                step_q <= step_q + StepW'(1);
                            end
                        end else begin
                            tile_y_q <= tile_y_q + CntW'(1);
                        end
                    end else begin
                        tile_x_q <= tile_x_q + CntW'(1);
                    end
                end else if (count_wrap) begin
                    inner_q <= inner_q + CntW'(1);
                end
            end
        end
    end

    // p1: lane mask for the beat accepted in the previous cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_mask_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= calc_en_o;
            if (calc_en_o) begin
                col_mask_p1 <= last_inner_o ? lane_mask(row, col0, cfg) : '1;
            end
        end
    end

    assign col_mask_o   = col_mask_p1;
    assign step_idx_o   = step_q;
    assign head_o       = head_q;
    assign tile_x_o     = tile_x_q;
    assign tile_y_o     = tile_y_q;
    assign inner_tile_o = inner_q;
    assign busy_o       = (state_q != IDLE);

`ifdef ITA_SEQ_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_q <= '0;
        end else if (run && inp_valid_i && weight_valid_i && credit_full) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule
